// File: rtl/uart_param.sv
// Full-duplex UART: a fractional baud-tick generator shared by independent TX and RX FSMs,
// with a majority-voting receiver and valid/ready handshakes on both word interfaces.
`timescale 1ns/1ps
module uart_param #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);
   localparam int unsigned INC  = BAUD * OVERSAMPLE;
   localparam int unsigned TW   = $clog2(OVERSAMPLE);
   localparam int unsigned BW   = $clog2(DATA_BITS);
   localparam int unsigned HALF = OVERSAMPLE / 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // Tick generator: one-clock tick at OVERSAMPLE x baud
   logic [31:0] acc;
   logic [32:0] acc_sum;
   logic        tick;

   assign acc_sum = {1'b0, acc} + 33'(INC);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (acc_sum >= 33'(CLK_HZ)) begin
         acc  <= 32'(acc_sum - 33'(CLK_HZ));
         tick <= 1'b1;
      end else begin
         acc  <= acc_sum[31:0];
         tick <= 1'b0;
      end
   end

   // Transmitter
   state_t               tx_state, tx_state_n;
   logic [TW-1:0]        tx_tcnt, tx_tcnt_n;
   logic [BW-1:0]        tx_bcnt, tx_bcnt_n;
   logic [DATA_BITS-1:0] tx_shreg, tx_shreg_n;
   logic                 tx_par, tx_par_n, tx_n, tx_ready_n, tx_bit_end;

   assign tx_bit_end = tick && (tx_tcnt == TW'(OVERSAMPLE - 1));

   always_comb begin
      tx_state_n = tx_state;
      tx_tcnt_n  = tx_tcnt;
      tx_bcnt_n  = tx_bcnt;
      tx_shreg_n = tx_shreg;
      tx_par_n   = tx_par;
      tx_n       = tx;
      tx_ready_n = tx_ready;
      if (tx_state != S_IDLE && tick)
         tx_tcnt_n = tx_bit_end ? '0 : tx_tcnt + TW'(1);
      case (tx_state)
         S_IDLE: if (tx_valid && tx_ready) begin
            tx_state_n = S_START;
            tx_n       = 1'b0;
            tx_ready_n = 1'b0;
            tx_tcnt_n  = '0;
            tx_shreg_n = tx_data;
            tx_par_n   = (PARITY == 1) ? ~^tx_data : ^tx_data;
         end
         S_START: if (tx_bit_end) begin
            tx_state_n = S_DATA;
            tx_n       = tx_shreg[0];
            tx_bcnt_n  = '0;
         end
         S_DATA: if (tx_bit_end) begin
            if (tx_bcnt == BW'(DATA_BITS - 1)) begin
               tx_bcnt_n = '0;
               if (PARITY != 0) begin
                  tx_state_n = S_PARITY;
                  tx_n       = tx_par;
               end else begin
                  tx_state_n = S_STOP;
                  tx_n       = 1'b1;
               end
            end else begin
               tx_shreg_n = tx_shreg >> 1;
               tx_n       = tx_shreg[1];
               tx_bcnt_n  = tx_bcnt + BW'(1);
            end
         end
         S_PARITY: if (tx_bit_end) begin
            tx_state_n = S_STOP;
            tx_n       = 1'b1;
            tx_bcnt_n  = '0;
         end
         S_STOP: if (tx_bit_end) begin
            if (tx_bcnt == BW'(STOP_BITS - 1)) begin
               tx_state_n = S_IDLE;
               tx_ready_n = 1'b1;
            end else begin
               tx_bcnt_n = tx_bcnt + BW'(1);
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx_shreg <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_tcnt  <= tx_tcnt_n;
         tx_bcnt  <= tx_bcnt_n;
         tx_shreg <= tx_shreg_n;
         tx_par   <= tx_par_n;
         tx       <= tx_n;
         tx_ready <= tx_ready_n;
      end
   end

   // Receiver
   logic rx_m, rx_s, rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   state_t               rx_state, rx_state_n;
   logic [TW-1:0]        rx_tcnt, rx_tcnt_n;
   logic [BW-1:0]        rx_bcnt, rx_bcnt_n;
   logic [DATA_BITS-1:0] rx_shreg, rx_shreg_n, rx_data_n;
   logic                 smp0, smp0_n, smp1, smp1_n, rx_par_bit, rx_par_bit_n;
   logic                 maj, rx_decide, rx_bit_end, rx_exp_par;
   logic                 rx_valid_n, rx_frame_err_n, rx_parity_err_n, rx_overrun_n;

   // Third vote is the live sample taken on the decision tick itself
   assign maj        = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
   assign rx_decide  = tick && (rx_tcnt == TW'(HALF + 1));
   assign rx_bit_end = tick && (rx_tcnt == TW'(OVERSAMPLE - 1));
   assign rx_exp_par = (PARITY == 1) ? ~^rx_shreg : ^rx_shreg;
   assign rx_busy    = (rx_state != S_IDLE);

   always_comb begin
      rx_state_n      = rx_state;
      rx_tcnt_n       = rx_tcnt;
      rx_bcnt_n       = rx_bcnt;
      rx_shreg_n      = rx_shreg;
      smp0_n          = smp0;
      smp1_n          = smp1;
      rx_par_bit_n    = rx_par_bit;
      rx_data_n       = rx_data;
      rx_valid_n      = rx_valid;
      rx_frame_err_n  = rx_frame_err;
      rx_parity_err_n = rx_parity_err;
      rx_overrun_n    = rx_overrun;
      if (rx_valid && rx_ready) begin
         rx_valid_n   = 1'b0;
         rx_overrun_n = 1'b0;
      end
      if (rx_state != S_IDLE && tick) begin
         rx_tcnt_n = rx_bit_end ? '0 : rx_tcnt + TW'(1);
         if (rx_tcnt == TW'(HALF - 1)) smp0_n = rx_s;
         if (rx_tcnt == TW'(HALF))     smp1_n = rx_s;
      end
      case (rx_state)
         S_IDLE: if (rx_prev && !rx_s) begin
            rx_state_n = S_START;
            rx_tcnt_n  = '0;
         end
         S_START: begin
            if (rx_decide && maj) begin
               rx_state_n = S_IDLE;
            end else if (rx_bit_end) begin
               rx_state_n = S_DATA;
               rx_bcnt_n  = '0;
            end
         end
         S_DATA: begin
            if (rx_decide)
               rx_shreg_n = {maj, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit_end) begin
               if (rx_bcnt == BW'(DATA_BITS - 1))
                  rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
               else
                  rx_bcnt_n = rx_bcnt + BW'(1);
            end
         end
         S_PARITY: begin
            if (rx_decide)  rx_par_bit_n = maj;
            if (rx_bit_end) rx_state_n   = S_STOP;
         end
         S_STOP: if (rx_decide) begin
            // Leave mid-stop so a following start edge can be caught immediately
            rx_state_n = S_IDLE;
            if (!rx_valid || rx_ready) begin
               rx_data_n       = rx_shreg;
               rx_frame_err_n  = ~maj;
               rx_parity_err_n = (PARITY != 0) && (rx_par_bit != rx_exp_par);
               rx_valid_n      = 1'b1;
            end else begin
               rx_overrun_n = 1'b1;
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state      <= S_IDLE;
         rx_tcnt       <= '0;
         rx_bcnt       <= '0;
         rx_shreg      <= '0;
         smp0          <= 1'b1;
         smp1          <= 1'b1;
         rx_par_bit    <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_state      <= rx_state_n;
         rx_tcnt       <= rx_tcnt_n;
         rx_bcnt       <= rx_bcnt_n;
         rx_shreg      <= rx_shreg_n;
         smp0          <= smp0_n;
         smp1          <= smp1_n;
         rx_par_bit    <= rx_par_bit_n;
         rx_data       <= rx_data_n;
         rx_valid      <= rx_valid_n;
         rx_frame_err  <= rx_frame_err_n;
         rx_parity_err <= rx_parity_err_n;
         rx_overrun    <= rx_overrun_n;
      end
   end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: 8N1 instance driven from a serial-line task, and an 8E2
// instance looped back onto itself.
`timescale 1ns/1ps
module tb_uart_param;
   localparam int BT = 434;  // clocks per bit at 50 MHz / 115200

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst;
   logic [7:0] tx_data0, rx_data0, tx_data1, rx_data1;
   logic       tx_valid0, tx_ready0, tx0, rx0, rx_drv, loop0;
   logic       rx_valid0, rx_ready0, fe0, pe0, ov0, busy0;
   logic       tx_valid1, tx_ready1, tx1, rx1;
   logic       rx_valid1, rx_ready1, fe1, pe1, ov1, busy1;

   assign rx0 = loop0 ? tx0 : rx_drv;
   assign rx1 = tx1;

   uart_param u0 (
      .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .tx(tx0), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
      .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ov0), .rx_busy(busy0));

   uart_param #(.PARITY(2), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
      .tx(tx1), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
      .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ov1), .rx_busy(busy1));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 8N1 frame onto rx_drv; optional inverted pulse of glen clocks centred in data bit gbit
   task automatic send_rx(input logic [7:0] d, input logic stop_v, input int gbit, input int glen);
      logic [9:0] fr;
      fr = {stop_v, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_drv = fr[b];
         if (glen > 0 && b == gbit + 1) begin
            wait_clk(BT/2 - glen/2);
            rx_drv = ~fr[b];
            wait_clk(glen);
            rx_drv = fr[b];
            wait_clk(BT - BT/2 + glen/2 - glen);
         end else begin
            wait_clk(BT);
         end
      end
      rx_drv = 1'b1;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop_v;
      int         gbit;
      int         glen;
      logic [7:0] exp_d;
      logic       exp_fe;
   } vec_t;

   vec_t vt[4];
   int   et[16];

   initial begin
      int ecount, rdy_at, t, n, e;
      logic prev;
      logic [10:0] expbits;

      vt[0] = '{8'hA5, 1'b1, -1, 0,  8'hA5, 1'b0};
      vt[1] = '{8'h81, 1'b0, -1, 0,  8'h81, 1'b1};
      vt[2] = '{8'h3C, 1'b1, 3,  1,  8'h3C, 1'b0};
      vt[3] = '{8'h5A, 1'b1, 6,  20, 8'h5A, 1'b0};

      rst = 1'b1; tx_data0 = '0; tx_valid0 = 1'b0; rx_drv = 1'b1; loop0 = 1'b0;
      rx_ready0 = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0; rx_ready1 = 1'b0;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);
      chk("rst_tx", tx0, 1);
      chk("rst_tx_ready", tx_ready0, 1);
      chk("rst_rx_valid", rx_valid0, 0);
      chk("rst_rx_data", rx_data0, 0);
      chk("rst_flags", {fe0, pe0, ov0}, 0);
      chk("rst_rx_busy", busy0, 0);

      // 0x55 on 8N1: every bit boundary is an edge
      tx_data0 = 8'h55; tx_valid0 = 1'b1;
      @(negedge clk); tx_valid0 = 1'b0;
      chk("b_tx_start", tx0, 0);
      chk("b_ready_low", tx_ready0, 0);
      prev = 1'b0; ecount = 0; rdy_at = -1;
      for (int c = 1; c <= 5000 && rdy_at < 0; c++) begin
         @(negedge clk);
         if (tx0 !== prev && ecount < 16) begin et[ecount] = c; ecount++; prev = tx0; end
         if (tx_ready0 === 1'b1) rdy_at = c;
      end
      chk("b_edge_count", ecount, 9);
      chk_rng("b_start_len", et[0], 400, 440);
      for (int k = 1; k < 9; k++) chk_rng($sformatf("b_bit%0d_len", k - 1), et[k] - et[k-1], 433, 436);
      chk_rng("b_stop_len", rdy_at - et[8], 433, 436);
      chk_rng("b_ready_low_len", rdy_at, 4310, 4350);
      chk("b_tx_idle", tx0, 1);

      // 0x07 on 8E2 with loopback: parity 1, two stop bits
      tx_data1 = 8'h07; tx_valid1 = 1'b1;
      @(negedge clk); tx_valid1 = 1'b0;
      t = 0;
      while (tx1 !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
      chk_rng("c_start_len", t, 400, 440);
      expbits = 11'b11100000111;
      for (int k = 0; k < 11; k++) begin
         wait_clk(k == 0 ? BT/2 : BT);
         chk($sformatf("c_bit%0d", k), tx1, expbits[k]);
      end
      e = 0;
      while (tx_ready1 !== 1'b1 && e < 600) begin @(negedge clk); e++; end
      chk_rng("c_frame_len", BT/2 + 10*BT + e, 4771, 4778);
      chk("c_rx_valid", rx_valid1, 1);
      chk("c_rx_data", rx_data1, 8'h07);
      chk("c_rx_perr", pe1, 0);
      chk("c_rx_ferr", fe1, 0);

      // Receive vectors on 8N1
      for (int i = 0; i < 4; i++) begin
         send_rx(vt[i].d, vt[i].stop_v, vt[i].gbit, vt[i].glen);
         wait_clk(20);
         chk($sformatf("v%0d_valid", i), rx_valid0, 1);
         chk($sformatf("v%0d_data", i), rx_data0, vt[i].exp_d);
         chk($sformatf("v%0d_ferr", i), fe0, vt[i].exp_fe);
         chk($sformatf("v%0d_perr", i), pe0, 0);
         chk($sformatf("v%0d_ovr", i), ov0, 0);
         rx_ready0 = 1'b1; wait_clk(1); rx_ready0 = 1'b0;
         chk($sformatf("v%0d_consumed", i), rx_valid0, 0);
         wait_clk(50);
      end

      // Overrun: second frame dropped while the first is unconsumed
      send_rx(8'hA3, 1'b1, -1, 0);
      send_rx(8'h3C, 1'b1, -1, 0);
      wait_clk(20);
      chk("o_valid", rx_valid0, 1);
      chk("o_data", rx_data0, 8'hA3);
      chk("o_overrun", ov0, 1);
      rx_ready0 = 1'b1; wait_clk(1); rx_ready0 = 1'b0;
      chk("o_valid_cleared", rx_valid0, 0);
      chk("o_overrun_cleared", ov0, 0);

      // False start: 100-clock low pulse
      wait_clk(100);
      rx_drv = 1'b0; wait_clk(50);
      chk("g_busy", busy0, 1);
      wait_clk(50); rx_drv = 1'b1;
      wait_clk(600);
      chk("g_idle", busy0, 0);
      chk("g_valid", rx_valid0, 0);
      chk("g_flags", {fe0, pe0, ov0}, 0);

      // Reset in the middle of a TX frame and an RX frame
      tx_data0 = 8'h99; tx_valid0 = 1'b1; rx_drv = 1'b0;
      @(negedge clk); tx_valid0 = 1'b0;
      wait_clk(2000);
      chk("r_rx_busy_mid", busy0, 1);
      chk("r_tx_ready_mid", tx_ready0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("r_tx_high", tx0, 1);
      chk("r_tx_ready", tx_ready0, 1);
      chk("r_rx_valid", rx_valid0, 0);
      chk("r_rx_busy", busy0, 0);
      rst = 1'b0; rx_drv = 1'b1;
      wait_clk(600);
      loop0 = 1'b1;
      wait_clk(10);
      tx_data0 = 8'h42; tx_valid0 = 1'b1;
      @(negedge clk); tx_valid0 = 1'b0;
      n = 0;
      while (rx_valid0 !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
      chk("r_rx42_valid", rx_valid0, 1);
      chk("r_rx42_data", rx_data0, 8'h42);
      chk("r_rx42_flags", {fe0, pe0, ov0}, 0);
      n = 0;
      while (tx_ready0 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      chk("r_tx42_done", tx_ready0, 1);
      chk("r_tx42_idle", tx0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Full-duplex UART with parametrised data width, parity, stop bits and baud rate.
- Independent TX and RX state machines, driven by a shared fractional baud-tick generator at OVERSAMPLE x baud.
- RX uses a 2-FF synchroniser, start-bit validation, 3-sample majority voting, and framing/parity/overrun flags.
- Valid/ready handshakes on both byte interfaces. Sits between the board serial pins and the command/data logic.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. Requires CLK_HZ >= 4*BAUD*OVERSAMPLE.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit. Even, and at least 8.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_data, input, DATA_BITS: byte to send. Sampled on the tx handshake.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: transmitter idle and able to accept data.
- tx, output, 1: serial out. Idle high.
- rx, input, 1: serial in. Asynchronous.
- rx_data, output, DATA_BITS: last received word, LSB first on the line.
- rx_valid, output, 1: rx_data is held and not yet consumed.
- rx_ready, input, 1: consumer accepts rx_data.
- rx_frame_err, output, 1: stop bit sampled low for the word in rx_data.
- rx_parity_err, output, 1: parity mismatch for the word in rx_data. Always 0 when PARITY=0.
- rx_overrun, output, 1: at least one frame was dropped while rx_valid was high.
- rx_busy, output, 1: RX state is not IDLE.

Behaviour:
- Reset values:
  - tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, all error flags = 0, rx_busy = 0.
  - Tick accumulator = 0. Both FSMs go to IDLE.
  - Reset mid-frame aborts immediately and tx returns high on the next edge.
- Tick generator:
  - 32-bit accumulator acc, incremented by INC = BAUD*OVERSAMPLE every clock.
  - When acc+INC >= CLK_HZ: acc <= acc+INC-CLK_HZ and tick = 1 for one clock. Otherwise tick = 0.
  - Long-run tick rate is exact, with jitter of at most 1 clk.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Handshake occurs when tx_valid & tx_ready. On that edge: latch tx_data, tx_ready <= 0, go to START, tx <= 0, tick counter <= 0.
  - Each state lasts exactly OVERSAMPLE ticks.
  - DATA shifts out DATA_BITS bits, LSB first.
  - PARITY state is skipped when PARITY=0. Odd parity bit = ~^data; even parity bit = ^data.
  - STOP drives 1 for STOP_BITS*OVERSAMPLE ticks, then returns to IDLE with tx_ready <= 1.
  - Back-to-back: with tx_valid held high, the next start bit begins on the clock after tx_ready rises, so there is no extra idle time.
- RX synchroniser: two flops. FSM logic uses only the second stage (rx_s).
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: on a 1->0 transition of rx_s, go to START with the tick counter cleared.
  - Sampling: samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit. Bit value = majority of the three.
  - START: if the start-bit majority is 1, the start is false; return to IDLE with no flags changed.
  - DATA shifts in DATA_BITS bits, LSB first. PARITY state is skipped when PARITY=0.
  - STOP: only the first stop bit is checked, even when STOP_BITS=2. Mid-stop decision is at tick OVERSAMPLE/2+1, then go straight to IDLE. This allows resync to a following start bit.
- Frame completion at the STOP decision:
  - If rx_valid is 0, or rx_valid & rx_ready in that same cycle: load rx_data, rx_frame_err and rx_parity_err, and set rx_valid <= 1.
  - Otherwise: drop the frame, set rx_overrun <= 1, and leave rx_data unchanged.
- RX consumer handshake (rx_valid & rx_ready):
  - rx_valid <= 0 and rx_overrun <= 0, unless a new frame loads in the same cycle. In that case rx_valid stays 1 with the new data and rx_overrun <= 0.
- Independence: TX and RX operate concurrently. Neither blocks the other.
- Widths: the bit counter is sized for DATA_BITS, and the tick counter is $clog2(OVERSAMPLE) bits. Counters do not wrap within a state.

Test Plan:
- Defaults; send 0x55 with tx_valid pulsed.
  - Required: tx waveform 0,1,0,1,0,1,0,1,0,1 then high.
  - Required: each bit 434 +/- 1 clk.
  - Required: tx_ready low for 10 bit times (4340 +/- 10 clk).
- PARITY=2, STOP_BITS=2; send 0x07.
  - Required: parity bit 1, two stop bits, frame 12 bits.
  - Required: loopback into rx gives rx_data = 0x07 with rx_parity_err = 0.
- rx receives 0xA3, then 0x3C, with rx_ready held 0.
  - Required: rx_data stays 0xA3 and rx_overrun = 1.
  - Required: after a single rx_ready pulse, rx_valid = 0 and rx_overrun = 0.
- rx glitch: low for 100 clk only.
  - Required: rx_busy pulses, then returns to IDLE with rx_valid = 0 and no flags.
  - Required: a single-clk glitch at the mid-bit sample of a data bit is rejected by the majority vote, and the byte is received correctly.
- rx frame 0x81 with the stop bit forced low.
  - Required: rx_valid = 1, rx_data = 0x81, rx_frame_err = 1.
- Assert rst halfway through a tx frame and an rx frame.
  - Required: tx = 1 on the next clk, tx_ready = 1, rx_valid = 0.
  - Required: a subsequent 0x42 transfers cleanly in both directions.
